countdown_ctrl: RTL
===================

# countdown_ctrl

Sequencing controller for an N-bit down counter: loads a start value, runs the count down under start/pause/resume/abort commands, stops at zero instead of wrapping, and flags terminal count. It sits between control logic (FSMs, register interfaces) and the down-counter datapath, turning the free-running down count into a controllable one-shot or periodic timer.

## Interface
Parameters:
- N, 5, counter width in bits
- DIV, 1, prescale ratio: count decrements once every DIV clk cycles (DIV ≥ 1)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; sampled on the clk rising edge
- load_val  in  N  start value, captured on an accepted start
- start  in  1  single-cycle command: load and run
- pause  in  1  single-cycle command: freeze count (RUN only)
- resume  in  1  single-cycle command: continue (PAUSE only)
- abort  in  1  single-cycle command: return to IDLE from any state
- auto_reload  in  1  present only with CDC_AUTO_RELOAD_EN; see Configuration
- count  out  N  current counter value
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse on terminal count
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset values: state=IDLE, count=0, busy=0, done=0, prescaler=0, latched load value=0.
- Command priority, highest first: reset > abort > start > pause/resume. Lower-priority commands in the same cycle are ignored.
- IDLE: count holds. start → count=load_val, load_val latched, prescaler cleared, state RUN. If load_val=0, go straight to DONE with count=0 and done=1.
- RUN: on each prescaler tick, count decrements by 1. On a tick with count=1: count=0, done=1, state DONE. start restarts with a fresh load_val and clears the prescaler. pause → PAUSE.
- PAUSE: count and prescaler frozen. resume → RUN, and the prescaler continues from its frozen value. start → reload as in IDLE. pause is ignored.
- DONE: lasts one cycle. Next state is IDLE with count held at 0 (see Configuration for auto-reload). start in DONE is accepted as from IDLE.
- abort in any state: count=0, prescaler=0, state IDLE, no done pulse.
- No underflow: count never goes below 0 and never wraps to 2^N−1.
- pause/resume in IDLE or DONE: ignored.
- All arithmetic is N-bit unsigned. The prescaler is $clog2(DIV)-bit, or absent when DIV=1.

## Timing
- All outputs are registered. Each command is sampled on edge k and takes effect on the outputs after edge k.
- DIV=1, start with load_val=L≥1 at edge k: count=L after k, L−1 after k+1, … 0 after k+L. done=1 for exactly the cycle after edge k+L.
- General DIV: the first decrement happens DIV edges after load. done appears L·DIV edges after load, excluding paused cycles.
- busy falls in the same cycle done rises.
- reset during RUN/PAUSE: all outputs return to reset values after that edge. A done that would have fired is suppressed.

## Configuration
- CDC_AUTO_RELOAD_EN defined: the auto_reload port exists. In DONE with auto_reload=1, count reloads to the latched load value, the prescaler clears, and state goes back to RUN on the next edge (periodic mode, done pulses every L·DIV+1 cycles). With auto_reload=0, DONE goes to IDLE. abort still stops the timer.
- CDC_AUTO_RELOAD_EN not defined: no auto_reload port. DONE always goes to IDLE (one-shot only).

## Structure
- A shared header holds the state encodings (CDC_IDLE, CDC_RUN, CDC_PAUSE, CDC_DONE) and the 2-bit state width.
- Natural sub-module: down_counter_ld. It is an N-bit down counter with synchronous load, enable and a zero flag, driven by the controller FSM plus the prescaler.

## Test plan
- Reset, then start with load_val=5, DIV=1 → count goes 5,4,3,2,1,0 on consecutive cycles; done=1 only in the cycle with count=0; state DONE then IDLE; busy low from then on.
- load_val=3, DIV=4; pause after count reaches 2, hold 10 cycles, then resume → count stays at 2 throughout the pause; total cycles from start to done = 12 + 10 + handshake cycles.
- start with load_val=0 → next cycle count=0, done=1, state DONE, busy never asserts.
- abort and start asserted together mid-RUN → abort wins: count=0, IDLE, no done pulse. Then start with load_val=31 (N=5) → count=31, no wrap at 0.
- reset asserted mid-RUN with count=2 → next cycle count=0, state IDLE, done=0.
- With CDC_AUTO_RELOAD_EN, auto_reload=1, load_val=2, DIV=1 → count sequence 2,1,0,2,1,0,… with done pulses every 3 cycles. Dropping auto_reload returns the block to IDLE after the next done.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Shared state encodings and widths for the countdown_ctrl sequencing controller.
package countdown_ctrl_pkg;

   localparam int CDC_STATE_W = 2;

   typedef logic [CDC_STATE_W-1:0] cdc_state_t;

   localparam cdc_state_t CDC_IDLE  = 2'd0;
   localparam cdc_state_t CDC_RUN   = 2'd1;
   localparam cdc_state_t CDC_PAUSE = 2'd2;
   localparam cdc_state_t CDC_DONE  = 2'd3;

endpackage

// File: rtl/countdown_ctrl_down_counter_ld.sv
// N-bit down counter with synchronous clear/load, decrement enable and a zero flag.
// Decrement saturates at zero so the count can never wrap.
module down_counter_ld #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         en,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - N'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/resume/abort sequencer for a prescaled down counter with terminal-count pulse.
// Optional periodic mode is enabled by defining CDC_AUTO_RELOAD_EN (adds the auto_reload port).
module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter int N   = 5,
   parameter int DIV = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           load_val,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   resume,
   input  logic                   abort,
`ifdef CDC_AUTO_RELOAD_EN
   input  logic                   auto_reload,
`endif
   output logic [N-1:0]           count,
   output logic                   busy,
   output logic                   done,
   output logic [CDC_STATE_W-1:0] state
);

   cdc_state_t   state_q, state_d;
   logic [N-1:0] ld_q, ld_d;
   logic [N-1:0] cnt_load_val;
   logic         cnt_clear, cnt_load, cnt_en, cnt_zero;
   logic         presc_clear, presc_adv, tick;
   logic         reload_req;

`ifdef CDC_AUTO_RELOAD_EN
   assign reload_req = auto_reload;
`else
   assign reload_req = 1'b0;
`endif

   generate
      if (DIV > 1) begin : g_presc
         localparam int PW = $clog2(DIV);
         logic [PW-1:0] presc_q;

         always_ff @(posedge clk) begin
            if (reset || presc_clear) begin
               presc_q <= '0;
            end else if (presc_adv) begin
               presc_q <= (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
            end
         end

         assign tick = (presc_q == PW'(DIV - 1));
      end else begin : g_no_presc
         logic unused_presc;
         assign unused_presc = presc_clear ^ presc_adv;
         assign tick = 1'b1;
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      ld_d         = ld_q;
      cnt_clear    = 1'b0;
      cnt_load     = 1'b0;
      cnt_en       = 1'b0;
      cnt_load_val = load_val;
      presc_clear  = 1'b0;
      presc_adv    = 1'b0;
      if (abort) begin
         state_d     = CDC_IDLE;
         cnt_clear   = 1'b1;
         presc_clear = 1'b1;
      end else if (start) begin
         ld_d        = load_val;
         cnt_load    = 1'b1;
         presc_clear = 1'b1;
         state_d     = (load_val == '0) ? CDC_DONE : CDC_RUN;
      end else begin
         case (state_q)
            CDC_RUN: begin
               // pause wins over a coincident tick so the frozen value is exact
               if (pause) begin
                  state_d = CDC_PAUSE;
               end else begin
                  presc_adv = 1'b1;
                  if (tick && !cnt_zero) begin
                     cnt_en = 1'b1;
                     if (count == N'(1)) state_d = CDC_DONE;
                  end
               end
            end
            CDC_PAUSE: begin
               if (resume) state_d = CDC_RUN;
            end
            CDC_DONE: begin
               if (reload_req && (ld_q != '0)) begin
                  state_d      = CDC_RUN;
                  cnt_load     = 1'b1;
                  cnt_load_val = ld_q;
                  presc_clear  = 1'b1;
               end else begin
                  state_d = CDC_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CDC_IDLE;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
      end
   end

   down_counter_ld #(
      .N (N)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_load_val),
      .count    (count),
      .zero     (cnt_zero)
   );

   assign state = state_q;
   assign busy  = (state_q == CDC_RUN) || (state_q == CDC_PAUSE);
   assign done  = (state_q == CDC_DONE);

endmodule
